// File: rtl/serial_frame_receiver_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_frame_receiver_pkg
// Brief    : State encoding and line levels shared by the serial frame receiver.
// Revision : 1.0 - initial release
// ============================================================================
package serial_frame_receiver_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        STOP = 2'd2
    } state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

endpackage : serial_frame_receiver_pkg
`default_nettype wire

// File: rtl/serial_frame_receiver_sipo_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : sipo_shift_reg
// Brief    : Serial-in/parallel-out left shift register, MSB received first.
// Revision : 1.0 - initial release
// ============================================================================
module sipo_shift_reg
    import serial_frame_receiver_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         sh,
    input  logic         sin,
    output logic [N-1:0] q
);

    logic [N-1:0] shreg_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
        end else if (clr) begin
            shreg_q <= '0;
        end else if (sh) begin
            shreg_q <= {shreg_q[N-2:0], sin};
        end
    end

    assign q = shreg_q;

endmodule : sipo_shift_reg
`default_nettype wire

// File: rtl/serial_frame_receiver.sv
`default_nettype none
// ============================================================================
// Module   : serial_frame_receiver
// Brief    : Start/N data/stop frame receiver clocked by an external bit strobe.
// Revision : 1.0 - initial release
// ============================================================================
module serial_frame_receiver
    import serial_frame_receiver_pkg::*;
#(
    parameter int N  = 8,
    parameter int CW = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         bit_en,
    input  logic         sin,
    output logic [N-1:0] data_out,
    output logic         valid,
    output logic         frame_err,
    output logic         busy
);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    data_q, data_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;
    logic            sh_clr, sh_en;
    logic [N-1:0]    shreg_q;

    sipo_shift_reg #(
        .N (N)
    ) u_sipo (
        .clk (clk),
        .rst (rst),
        .clr (sh_clr),
        .sh  (sh_en),
        .sin (sin),
        .q   (shreg_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    // Pulses default low every cycle so they last one clk regardless of strobe spacing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        sh_clr  = 1'b0;
        sh_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bit_en && (sin == START_LEVEL)) begin
                    state_d = RECV;
                    cnt_d   = '0;
                    sh_clr  = 1'b1;
                end
            end
            RECV: begin
                if (bit_en) begin
                    sh_en = 1'b1;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(N - 1)) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (bit_en) begin
                    state_d = IDLE;
                    if (sin == IDLE_LEVEL) begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign data_out  = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != IDLE);

endmodule : serial_frame_receiver
`default_nettype wire

// File: tb/tb_serial_frame_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_frame_receiver
// Brief    : Directed self-checking bench for serial_frame_receiver (N=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_frame_receiver;

    localparam int N  = 8;
    localparam int CW = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         bit_en;
    logic         sin;
    logic [N-1:0] data_out;
    logic         valid;
    logic         frame_err;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    int valid_cnt   = 0;
    int ferr_cnt    = 0;
    int overlap_cnt = 0;
    int busy_cycles = 0;
    int strobe_idx  = 0;
    int valid_stamp[$];

    serial_frame_receiver #(
        .N  (N),
        .CW (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bit_en    (bit_en),
        .sin       (sin),
        .data_out  (data_out),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Pulse/busy monitor sampled on the inactive edge.
    always @(negedge clk) begin
        if (valid)              valid_cnt++;
        if (frame_err)          ferr_cnt++;
        if (valid && frame_err) overlap_cnt++;
        if (busy)               busy_cycles++;
    end

    task automatic clear_counters();
        valid_cnt   = 0;
        ferr_cnt    = 0;
        overlap_cnt = 0;
        busy_cycles = 0;
        strobe_idx  = 0;
        valid_stamp.delete();
    endtask

    // One strobe: drive on negedge, return 1 time unit after the sampling edge.
    task automatic send_bit(input logic b);
        @(negedge clk);
        bit_en = 1'b1;
        sin    = b;
        @(posedge clk);
        #1;
        strobe_idx++;
        if (valid) valid_stamp.push_back(strobe_idx);
    endtask

    task automatic go_idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            bit_en = 1'b0;
            sin    = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [N-1:0] d, input logic stop_b);
        send_bit(1'b0);
        for (int i = N - 1; i >= 0; i--) send_bit(d[i]);
        send_bit(stop_b);
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        bit_en = 1'b0;
        sin    = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (data_out !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_data_out: got %h expected 00", data_out);
        end
        n_checks++;
        if ({valid, frame_err, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got valid/ferr/busy=%b expected 000", {valid, frame_err, busy});
        end
        rst = 1'b0;
        go_idle(2);
    endtask

    task automatic test_basic_frame();
        clear_counters();
        send_frame(8'hB2, 1'b1);
        n_checks++;
        if (valid !== 1'b1 || data_out !== 8'hB2) begin
            n_fail++;
            $display("FAIL basic_valid: got valid=%b data=%h expected valid=1 data=b2", valid, data_out);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_busy_after_stop: got %b expected 0", busy);
        end
        go_idle(1);
        @(posedge clk); #1;
        n_checks++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_valid_width: valid still %b, expected 0", valid);
        end
        go_idle(2);
        n_checks++;
        if (busy_cycles != 9 || valid_cnt != 1 || ferr_cnt != 0) begin
            n_fail++;
            $display("FAIL basic_counts: busy=%0d valid=%0d ferr=%0d expected 9/1/0",
                     busy_cycles, valid_cnt, ferr_cnt);
        end
    endtask

    // Strobe every 4th cycle; internal state must not move between strobes.
    task automatic test_slow_strobe();
        logic [N-1:0]  frame;
        logic [N-1:0]  exp_sh;
        logic [CW-1:0] exp_cnt;
        int            hold_bad;
        clear_counters();
        frame    = 8'hB2;
        exp_sh   = '0;
        exp_cnt  = '0;
        hold_bad = 0;
        for (int k = 0; k < N + 2; k++) begin
            if (k == 0) begin
                send_bit(1'b0);
            end else if (k <= N) begin
                send_bit(frame[N-k]);
                exp_sh  = {exp_sh[N-2:0], frame[N-k]};
                exp_cnt = CW'(k);
            end else begin
                send_bit(1'b1);
            end
            for (int h = 0; h < 3; h++) begin
                @(negedge clk);
                bit_en = 1'b0;
                @(posedge clk); #1;
                if (dut.cnt_q !== exp_cnt || dut.shreg_q !== exp_sh || busy !== (k <= N)) begin
                    hold_bad++;
                    $display("FAIL slow_hold k=%0d: cnt=%0d sh=%h busy=%b expected cnt=%0d sh=%h busy=%b",
                             k, dut.cnt_q, dut.shreg_q, busy, exp_cnt, exp_sh, (k <= N));
                end
            end
        end
        n_checks++;
        if (hold_bad != 0) n_fail++;
        n_checks++;
        if (data_out !== 8'hB2 || valid_cnt != 1 || ferr_cnt != 0) begin
            n_fail++;
            $display("FAIL slow_result: data=%h valid=%0d ferr=%0d expected b2/1/0",
                     data_out, valid_cnt, ferr_cnt);
        end
        go_idle(1);
    endtask

    task automatic test_frame_error();
        clear_counters();
        send_frame(8'h5A, 1'b0);
        n_checks++;
        if (frame_err !== 1'b1 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ferr_pulse: got ferr=%b valid=%b expected 1/0", frame_err, valid);
        end
        go_idle(3);
        n_checks++;
        if (data_out !== 8'hB2 || ferr_cnt != 1 || valid_cnt != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ferr_result: data=%h ferr=%0d valid=%0d busy=%b expected b2/1/0/0",
                     data_out, ferr_cnt, valid_cnt, busy);
        end
    endtask

    task automatic test_back_to_back();
        clear_counters();
        send_frame(8'h80, 1'b1);
        n_checks++;
        if (valid !== 1'b1 || data_out !== 8'h80) begin
            n_fail++;
            $display("FAIL b2b_first: valid=%b data=%h expected 1/80", valid, data_out);
        end
        send_frame(8'h01, 1'b1);
        n_checks++;
        if (valid !== 1'b1 || data_out !== 8'h01) begin
            n_fail++;
            $display("FAIL b2b_second: valid=%b data=%h expected 1/01", valid, data_out);
        end
        go_idle(2);
        n_checks++;
        if (valid_stamp.size() != 2) begin
            n_fail++;
            $display("FAIL b2b_pulses: got %0d valid pulses expected 2", valid_stamp.size());
        end else if (valid_stamp[1] - valid_stamp[0] != 10) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d strobes expected 10", valid_stamp[1] - valid_stamp[0]);
        end
    endtask

    task automatic test_async_reset();
        clear_counters();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (data_out !== 8'h00 || {valid, frame_err, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL async_reset: data=%h v/f/b=%b expected 00/000",
                     data_out, {valid, frame_err, busy});
        end
        go_idle(2);
        rst = 1'b0;
        go_idle(1);
        n_checks++;
        if (valid_cnt != 0 || ferr_cnt != 0) begin
            n_fail++;
            $display("FAIL async_reset_pulses: valid=%0d ferr=%0d expected 0/0", valid_cnt, ferr_cnt);
        end
        send_frame(8'hFF, 1'b1);
        n_checks++;
        if (valid !== 1'b1 || data_out !== 8'hFF) begin
            n_fail++;
            $display("FAIL async_reset_recover: valid=%b data=%h expected 1/ff", valid, data_out);
        end
        go_idle(2);
    endtask

    task automatic test_idle_line();
        clear_counters();
        for (int i = 0; i < 50; i++) send_bit(1'b1);
        go_idle(2);
        n_checks++;
        if (busy_cycles != 0 || valid_cnt != 0 || ferr_cnt != 0) begin
            n_fail++;
            $display("FAIL idle_line: busy=%0d valid=%0d ferr=%0d expected 0/0/0",
                     busy_cycles, valid_cnt, ferr_cnt);
        end
        n_checks++;
        if (data_out !== 8'hFF) begin
            n_fail++;
            $display("FAIL idle_data_hold: got %h expected ff", data_out);
        end
    endtask

    task automatic test_no_overlap();
        n_checks++;
        if (overlap_cnt != 0) begin
            n_fail++;
            $display("FAIL overlap: valid and frame_err high together %0d times", overlap_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_slow_strobe();
        test_frame_error();
        test_back_to_back();
        test_no_overlap();
        test_async_reset();
        test_idle_line();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_serial_frame_receiver
`default_nettype wire
